// File: rtl/cmp_window_pkg.sv
// cmp_window_pkg: class encoding and classification helpers for the window comparator
package cmp_pkg;
  localparam int W = 64;
  typedef enum logic [1:0] {
    NONE   = 2'b00,
    BELOW  = 2'b01,
    INSIDE = 2'b10,
    ABOVE  = 2'b11
  } cls_t;
  // Operands arrive already extended to W bits, so callers pass signed_mode=1 to
  // keep N+1-bit semantics even when a hysteresis margin pushes a threshold past the N-bit range.
  function automatic cls_t classify(input logic [W-1:0] a, input logic [W-1:0] lo,
                                    input logic [W-1:0] hi, input logic signed_mode);
    logic lt, gt, bad;
    lt  = signed_mode ? ($signed(a) < $signed(lo)) : (a < lo);
    gt  = signed_mode ? ($signed(a) > $signed(hi)) : (a > hi);
    bad = signed_mode ? ($signed(lo) > $signed(hi)) : (lo > hi);
    return bad ? NONE : lt ? BELOW : gt ? ABOVE : INSIDE;
  endfunction
  function automatic logic [2:0] cls_to_onehot(input cls_t c);
    return {c == ABOVE, c == INSIDE, c == BELOW};
  endfunction
endpackage

// File: rtl/cmp_window_if.sv
// cmp_window_if: sample/threshold inputs and classified outputs of the window comparator
interface cmp_window_if #(parameter int N = 8);
  logic         in_valid;
  logic [N-1:0] A;
  logic [N-1:0] LO;
  logic [N-1:0] HI;
  logic         BELOW;
  logic         INSIDE;
  logic         ABOVE;
  logic         changed;
  logic         win_err;
  modport master (output in_valid, A, LO, HI, input BELOW, INSIDE, ABOVE, changed, win_err);
  modport slave  (input in_valid, A, LO, HI, output BELOW, INSIDE, ABOVE, changed, win_err);
endinterface

// File: rtl/cmp_window_debounce.sv
// cmp_debounce: commits a 2-bit class once DEBOUNCE consecutive valid samples agree
module cmp_debounce import cmp_pkg::*; #(
  parameter int DEBOUNCE = 3
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_valid,
  input  cls_t i_cls,
  output cls_t o_cls,
  output logic o_changed
);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] MAX = CW'(DEBOUNCE);
  cls_t          r_cand, r_com, w_cand;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_chg, w_commit;
  // Next candidate/count; a NONE sample drops the candidate, a new class restarts at 1
  always_comb begin
    w_cand   = i_valid ? i_cls : r_cand;
    w_cnt    = !i_valid ? r_cnt : i_cls == NONE ? '0 : i_cls != r_cand ? CW'(1) :
               r_cnt == MAX ? MAX : r_cnt + 1'b1;
    w_commit = i_valid && w_cnt == MAX && w_cand != r_com;
  end
  // Candidate, count and committed class state with a one-cycle commit pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cand <= NONE;
      r_cnt  <= '0;
      r_com  <= NONE;
      r_chg  <= 1'b0;
    end else begin
      r_cand <= w_cand;
      r_cnt  <= w_cnt;
      r_chg  <= w_commit;
      if (w_commit) r_com <= w_cand;
    end
  end
  assign o_cls     = r_com;
  assign o_changed = r_chg;
endmodule

// File: rtl/cmp_window.sv
// cmp_window: debounced window comparator; CMP_WINDOW_HYST_EN widens the window by HYST while INSIDE
module cmp_window import cmp_pkg::*; #(
  parameter int N        = 8,
  parameter int SIGNED   = 0,
  parameter int DEBOUNCE = 3,
  parameter int HYST     = 0
) (
  input logic         clk,
  input logic         reset_n,
  cmp_window_if.slave bus
);
  logic [W-1:0] w_a, w_lo, w_hi, w_lo_t, w_hi_t;
  logic         w_bad, w_chg;
  cls_t         w_raw, w_com, r_raw;
  logic         r_s1_valid, r_win_err, r_changed;
  logic [2:0]   r_oh;
  function automatic logic [W-1:0] ext(input logic [N-1:0] v);
    return {{(W-N){(SIGNED != 0) && v[N-1]}}, v};
  endfunction
  assign w_a   = ext(bus.A);
  assign w_lo  = ext(bus.LO);
  assign w_hi  = ext(bus.HI);
  assign w_bad = $signed(w_lo) > $signed(w_hi);
`ifdef CMP_WINDOW_HYST_EN
  assign w_lo_t = w_com == INSIDE ? w_lo - W'(HYST) : w_lo;
  assign w_hi_t = w_com == INSIDE ? w_hi + W'(HYST) : w_hi;
`else
  logic w_unused_hyst;
  assign w_unused_hyst = |HYST;
  assign w_lo_t = w_lo;
  assign w_hi_t = w_hi;
`endif
  assign w_raw = w_bad ? NONE : classify(w_a, w_lo_t, w_hi_t, 1'b1);
  // Stage 1: register the raw class of each accepted sample; raw is held across gaps
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_raw      <= NONE;
      r_s1_valid <= 1'b0;
      r_win_err  <= 1'b0;
    end else begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_raw     <= w_raw;
        r_win_err <= w_bad;
      end
    end
  end
  cmp_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_valid   (r_s1_valid),
    .i_cls     (r_raw),
    .o_cls     (w_com),
    .o_changed (w_chg)
  );
  // Output stage: one-hot committed class and change pulse
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_oh      <= 3'b000;
      r_changed <= 1'b0;
    end else begin
      r_oh      <= cls_to_onehot(w_com);
      r_changed <= w_chg;
    end
  end
  assign bus.BELOW   = r_oh[0];
  assign bus.INSIDE  = r_oh[1];
  assign bus.ABOVE   = r_oh[2];
  assign bus.changed = r_changed;
  assign bus.win_err = r_win_err;
endmodule

// File: doc/cmp_window.md
Name: cmp_window

Overview:
- Parametrised, debounced window comparator; successor to the single-pair registered comparator.
- Classifies each valid sample A against a programmable window [LO, HI] as BELOW / INSIDE / ABOVE.
- Commits a class only after DEBOUNCE consecutive valid samples agree; registered one-hot outputs plus a change pulse.
- Used in front of threshold-monitor / alarm logic where single-sample glitches must not toggle flags.

Parameters:
- N, 8, data and threshold width.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned.
- DEBOUNCE, 3, consecutive agreeing samples needed to commit; legal range >= 1.
- HYST, 0, hysteresis margin in LSBs; used only with CMP_WINDOW_HYST_EN.

Ports:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  A/LO/HI sampled when high.
- A  in  N  sample.
- LO  in  N  lower threshold.
- HI  in  N  upper threshold.
- BELOW  out  1  committed class A<LO.
- INSIDE  out  1  committed class LO<=A<=HI.
- ABOVE  out  1  committed class A>HI.
- changed  out  1  one-cycle pulse on every commit that alters the class.
- win_err  out  1  last valid sample had LO>HI.

Behaviour:
- Interface: one clock, clk; reset_n asynchronous, active-low; all state clears immediately on assertion.
- Reset values: BELOW/INSIDE/ABOVE/changed/win_err = 0; committed class = NONE; candidate = NONE; count = 0; s1_valid = 0.
- Stage 1, on edge with in_valid=1: raw class registered with s1_valid=1.
  - Raw class is BELOW if A<LO, ABOVE if A>HI, else INSIDE.
  - Signedness per SIGNED.
  - If LO>HI, raw = NONE and win_err is set; it stays set until a valid sample with LO<=HI.
  - in_valid=0 clears s1_valid; raw is held.
- Stage 2 acts only when s1_valid=1.
  - raw==NONE: candidate=NONE, count=0, committed held.
  - raw==candidate: count saturates at DEBOUNCE.
  - Otherwise: candidate=raw, count=1.
  - When the post-update count == DEBOUNCE and candidate != committed: committed=candidate and changed=1 for that cycle only.
- Gaps in in_valid do not reset the count. Agreement is counted in samples, not cycles.
- Latency: outputs update on the 2nd rising edge after the acceptance edge of the DEBOUNCE-th agreeing sample.
- With DEBOUNCE=1, every class change commits at latency 2.
- Outputs are one-hot or all-zero (before the first commit only). Never two outputs high at once.
- Reset mid-count discards the candidate. Counting restarts from 0 after release.

Optional Feature:
- Macro: CMP_WINDOW_HYST_EN.
- Defined, while committed==INSIDE: BELOW needs A < LO-HYST; ABOVE needs A > HI+HYST.
  - Arithmetic at N+1 bits, sign- or zero-extended per SIGNED, so thresholds never wrap.
  - In other committed states, plain thresholds apply.
- Undefined: HYST is ignored and no extra adders are generated.

Decomposition:
- Package cmp_pkg holds:
  - Class typedef: NONE=2'b00, BELOW=2'b01, INSIDE=2'b10, ABOVE=2'b11.
  - Function classify(A, LO, HI, signed_mode).
  - Function cls_to_onehot.
- Sub-module cmp_debounce: generic DEBOUNCE-deep candidate/count/commit logic on a 2-bit class. The top level instantiates it once.

Test Plan (N=8, DEBOUNCE=3, LO=20, HI=100 unless stated):
- Reset: hold reset_n=0 with A=50 and in_valid=1 -> all outputs 0. Release, then A=50 valid on edges 1-3 -> INSIDE=1 and changed=1 after edge 5. changed=0 after edge 6.
- Glitch rejection: committed INSIDE; valid A sequence 50,150,50,150,50 -> INSIDE stays 1, ABOVE and changed never assert.
- Gapped samples: A=150 valid, 5 idle cycles, then 150,150 -> ABOVE=1 two edges after the third sample, with one changed pulse.
- Signedness: LO=0xF6, HI=0x0A, A=0x80 x3 -> SIGNED=1 gives BELOW; SIGNED=0 gives win_err=1 with outputs held. Then LO=0x14, HI=0x64 -> win_err clears on the next valid sample.
- Reset mid-operation: two A=5 samples, assert reset_n for 1 cycle, one more A=5 -> no commit. Two further A=5 samples -> BELOW=1.
- HYST (macro defined, HYST=4): committed INSIDE; A=103 x3 -> stays INSIDE. A=105 x3 -> ABOVE. Then A=98 x3 -> INSIDE.
